// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the RV32IM decode/issue stage.
//
// Contents:
//   ALU_* : 6-bit ALU select codes driven on ALU_SELECT
//   OPC_* : RV32 major opcodes (INSTR[6:0])
//   ST_*  : issue-slot state encoding (EMPTY / HOLD / FULL)
package alu_pkg;

    localparam logic [5:0] ALU_ADD    = 6'b000000;
    localparam logic [5:0] ALU_SLL    = 6'b000001;
    localparam logic [5:0] ALU_SLT    = 6'b000010;
    localparam logic [5:0] ALU_SLTU   = 6'b000011;
    localparam logic [5:0] ALU_XOR    = 6'b000100;
    localparam logic [5:0] ALU_SRL    = 6'b000101;
    localparam logic [5:0] ALU_OR     = 6'b000110;
    localparam logic [5:0] ALU_AND    = 6'b000111;
    localparam logic [5:0] ALU_MUL    = 6'b001000;
    localparam logic [5:0] ALU_MULH   = 6'b001001;
    localparam logic [5:0] ALU_MULHSU = 6'b001010;
    localparam logic [5:0] ALU_MULHU  = 6'b001011;
    localparam logic [5:0] ALU_DIV    = 6'b001100;
    localparam logic [5:0] ALU_REM    = 6'b001101;
    localparam logic [5:0] ALU_REMU   = 6'b001111;
    localparam logic [5:0] ALU_SUB    = 6'b010000;
    localparam logic [5:0] ALU_SRA    = 6'b010101;
    localparam logic [5:0] ALU_FWD    = 6'b011000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: purely combinational RV32I(M) decode to ALU select,
// operands, destination register, writeback enable and illegal flag.
//
// Configuration macro: RV32M_EN. When undefined, every funct7=0000001
// OP encoding decodes as illegal and is_m never asserts.
//
// Ports:
//   instr      in  32  instruction word
//   pc         in  32  instruction address
//   rs1_data   in  32  rs1 register value
//   rs2_data   in  32  rs2 register value
//   alu_select out  6  ALU operation code
//   data1      out 32  ALU operand 1
//   data2      out 32  ALU operand 2
//   rd         out  5  destination register field
//   reg_write  out  1  writeback enable (0 for rd=x0 or illegal)
//   illegal    out  1  unsupported or undefined encoding
//   is_m       out  1  legal M-extension op (needs settle time)
module alu_op_decode (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [5:0]  alu_select,
    output logic [31:0] data1,
    output logic [31:0] data2,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        illegal,
    output logic        is_m
);
    import alu_pkg::*;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};
    assign rd     = instr[11:7];

    // Illegal encodings are scrubbed at the end so every branch above can
    // set operands freely; rd=x0 never writes back.
    always_comb begin
        alu_select = ALU_ADD;
        data1      = 32'b0;
        data2      = 32'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        is_m       = 1'b0;
        case (opcode)
            OPC_OP: begin
                data1     = rs1_data;
                data2     = rs2_data;
                reg_write = 1'b1;
                case (f7)
                    7'b0000000: alu_select = {3'b000, f3};
                    7'b0100000: begin
                        if (f3 == 3'b000)      alu_select = ALU_SUB;
                        else if (f3 == 3'b101) alu_select = ALU_SRA;
                        else                   illegal    = 1'b1;
                    end
                    7'b0000001: begin
`ifdef RV32M_EN
                        is_m = 1'b1;
                        case (f3)
                            3'b100:  alu_select = ALU_DIV;
                            3'b110:  alu_select = ALU_REM;
                            3'b111:  alu_select = ALU_REMU;
                            3'b101:  illegal    = 1'b1;
                            default: alu_select = {3'b001, f3};
                        endcase
`else
                        illegal = 1'b1;
`endif
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                data1     = rs1_data;
                reg_write = 1'b1;
                alu_select = {3'b000, f3};
                if (f3 == 3'b101 && instr[30]) alu_select = ALU_SRA;
                // Shifts take the unsigned shamt, not the sign-extended imm.
                if (f3 == 3'b001 || f3 == 3'b101) data2 = shamt;
                else                              data2 = imm_i;
            end
            OPC_LOAD: begin
                data1     = rs1_data;
                data2     = imm_i;
                reg_write = 1'b1;
            end
            OPC_STORE: begin
                data1 = rs1_data;
                data2 = imm_s;
            end
            OPC_BRANCH: begin
                data1 = rs1_data;
                data2 = rs2_data;
                case (f3)
                    3'b000, 3'b001: alu_select = ALU_SUB;
                    3'b100, 3'b101: alu_select = ALU_SLT;
                    3'b110, 3'b111: alu_select = ALU_SLTU;
                    default:        illegal    = 1'b1;
                endcase
            end
            OPC_LUI: begin
                alu_select = ALU_FWD;
                data2      = imm_u;
                reg_write  = 1'b1;
            end
            OPC_AUIPC: begin
                data1     = pc;
                data2     = imm_u;
                reg_write = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                data1     = pc;
                data2     = 32'd4;
                reg_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            alu_select = ALU_ADD;
            data1      = 32'b0;
            data2      = 32'b0;
            reg_write  = 1'b0;
            is_m       = 1'b0;
        end
        if (rd == 5'd0) reg_write = 1'b0;
    end

endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: decode/issue stage with a single registered output slot.
// Accepts an instruction plus operands on a valid/ready handshake, decodes
// it and presents ALU select/operands downstream. M-extension ops sit in
// HOLD for M_HOLD_CYCLES extra cycles before OUT_VALID rises.
//
// Configuration macro: RV32M_EN (M ops decoded and HOLD used when defined;
// otherwise M encodings are illegal and the hold counter is absent).
//
// Ports:
//   CLK, RESET_N       clock (rising edge), async active-low reset
//   FLUSH              synchronous kill, overrides all transitions
//   IN_VALID/IN_READY  upstream handshake
//   INSTR, PC          instruction word and address
//   RS1_DATA, RS2_DATA register operands
//   OUT_VALID/OUT_READY downstream handshake
//   ALU_SELECT, ALU_DATA1, ALU_DATA2, RD, REG_WRITE, ILLEGAL  issued op
module alu_op_issue #(
    parameter int M_HOLD_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        FLUSH,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] INSTR,
    input  logic [31:0] PC,
    input  logic [31:0] RS1_DATA,
    input  logic [31:0] RS2_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [5:0]  ALU_SELECT,
    output logic [31:0] ALU_DATA1,
    output logic [31:0] ALU_DATA2,
    output logic [4:0]  RD,
    output logic        REG_WRITE,
    output logic        ILLEGAL
);
    import alu_pkg::*;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [1:0]  load_state;
    logic        accept;
    logic [5:0]  dec_select;
    logic [31:0] dec_data1;
    logic [31:0] dec_data2;
    logic [4:0]  dec_rd;
    logic        dec_reg_write;
    logic        dec_illegal;
    logic        dec_is_m;

    alu_op_decode u_decode (
        .instr      (INSTR),
        .pc         (PC),
        .rs1_data   (RS1_DATA),
        .rs2_data   (RS2_DATA),
        .alu_select (dec_select),
        .data1      (dec_data1),
        .data2      (dec_data2),
        .rd         (dec_rd),
        .reg_write  (dec_reg_write),
        .illegal    (dec_illegal),
        .is_m       (dec_is_m)
    );

    // A full slot can take a new op in the same cycle it is drained.
    assign IN_READY  = (state == ST_EMPTY) || ((state == ST_FULL) && OUT_READY);
    assign OUT_VALID = (state == ST_FULL);
    assign accept    = IN_VALID && IN_READY && !FLUSH;

`ifdef RV32M_EN
    localparam int   CNT_W   = (M_HOLD_CYCLES > 1) ? $clog2(M_HOLD_CYCLES) : 1;
    localparam logic HOLD_EN = (M_HOLD_CYCLES > 0);

    logic [CNT_W-1:0] hold_cnt;
    logic             enter_hold;

    assign enter_hold = accept && dec_is_m && HOLD_EN;
    assign load_state = enter_hold ? ST_HOLD : ST_FULL;

    // Counter is loaded with N-1 so HOLD lasts exactly N cycles.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hold_cnt <= '0;
        end else if (FLUSH) begin
            hold_cnt <= '0;
        end else if (enter_hold) begin
            hold_cnt <= CNT_W'(M_HOLD_CYCLES - 1);
        end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - CNT_W'(1);
        end
    end
`else
    logic unused_cfg;

    assign load_state = ST_FULL;
    assign unused_cfg = (M_HOLD_CYCLES > 0) | dec_is_m;
`endif

    always_comb begin
        state_next = state;
        if (FLUSH) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) state_next = load_state;
                end
                ST_FULL: begin
                    if (accept)         state_next = load_state;
                    else if (OUT_READY) state_next = ST_EMPTY;
                end
                ST_HOLD: begin
`ifdef RV32M_EN
                    if (hold_cnt == '0) state_next = ST_FULL;
`else
                    state_next = ST_EMPTY;
`endif
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_EMPTY;
        else          state <= state_next;
    end

    // Output slot only changes on acceptance, so a stalled FULL slot stays
    // bit-exact and HOLD presents the pending op with OUT_VALID low.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ALU_SELECT <= 6'b0;
            ALU_DATA1  <= 32'b0;
            ALU_DATA2  <= 32'b0;
            RD         <= 5'b0;
            REG_WRITE  <= 1'b0;
            ILLEGAL    <= 1'b0;
        end else if (accept) begin
            ALU_SELECT <= dec_select;
            ALU_DATA1  <= dec_data1;
            ALU_DATA2  <= dec_data2;
            RD         <= dec_rd;
            REG_WRITE  <= dec_reg_write;
            ILLEGAL    <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: directed self-checking bench for alu_op_issue.
// Builds with or without RV32M_EN; M-op expectations follow the macro.
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  alu_select;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] sel;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] rdn;
        logic [31:0] wr;
        logic [31:0] ill;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    alu_op_issue #(.M_HOLD_CYCLES(2)) dut (
        .CLK        (clk),
        .RESET_N    (reset_n),
        .FLUSH      (flush),
        .IN_VALID   (in_valid),
        .IN_READY   (in_ready),
        .INSTR      (instr),
        .PC         (pc),
        .RS1_DATA   (rs1_data),
        .RS2_DATA   (rs2_data),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .ALU_SELECT (alu_select),
        .ALU_DATA1  (alu_data1),
        .ALU_DATA2  (alu_data2),
        .RD         (rd),
        .REG_WRITE  (reg_write),
        .ILLEGAL    (illegal)
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rdn);
        return {f7, rs2, rs1, f3, rdn, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rdn,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rdn, op};
    endfunction

    function automatic vec_t make_vec(input logic [31:0] i, input logic [31:0] p,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] s, input logic [31:0] d1,
                                      input logic [31:0] d2, input logic [31:0] r,
                                      input logic [31:0] w, input logic [31:0] il);
        vec_t v;
        v.instr = i;  v.pc = p;   v.rs1 = a;  v.rs2 = b;  v.sel = s;
        v.d1 = d1;    v.d2 = d2;  v.rdn = r;  v.wr = w;   v.ill = il;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        instr     = i;
        pc        = p;
        rs1_data  = a;
        rs2_data  = b;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = make_vec({20'h12345, 5'd7, 7'b0110111}, 32'h200, 32'hAAAA, 32'hBBBB,
                           32'h18, 32'h0, 32'h12345000, 32'd7, 32'd1, 32'd0);
        vecs[1] = make_vec(enc_r(7'b0000001, 5'd2, 5'd1, 3'b101, 5'd10), 32'h204, 32'd100, 32'd7,
                           32'h0, 32'h0, 32'h0, 32'd10, 32'd0, 32'd1);
        vecs[2] = make_vec(enc_i(12'd1, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'h208, 32'h0, 32'h0,
                           32'h0, 32'h0, 32'h1, 32'd0, 32'd0, 32'd0);
        vecs[3] = make_vec({7'b0, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011}, 32'h20C, 32'd3, 32'd9,
                           32'h03, 32'd3, 32'd9, 32'd0, 32'd0, 32'd0);
        vecs[4] = make_vec({20'h00001, 5'd11, 7'b0010111}, 32'h400, 32'h5, 32'h6,
                           32'h0, 32'h400, 32'h1000, 32'd11, 32'd1, 32'd0);
        vecs[5] = make_vec({20'h0, 5'd12, 7'b1111111}, 32'h404, 32'h5, 32'h6,
                           32'h0, 32'h0, 32'h0, 32'd12, 32'd0, 32'd1);
        vecs[6] = make_vec(enc_i(12'hFF8, 5'd1, 3'b010, 5'd13, 7'b0000011), 32'h408, 32'h1000, 32'h0,
                           32'h0, 32'h1000, 32'hFFFFFFF8, 32'd13, 32'd1, 32'd0);
        vecs[7] = make_vec(enc_i(12'd0, 5'd5, 3'b000, 5'd1, 7'b1100111), 32'h300, 32'h77, 32'h0,
                           32'h0, 32'h300, 32'd4, 32'd1, 32'd1, 32'd0);
        vecs[8] = make_vec(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd14), 32'h304, 32'd50, 32'd8,
                           32'h10, 32'd50, 32'd8, 32'd14, 32'd1, 32'd0);

        reset_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_select", 32'(alu_select), 32'd0);
        checkOutput("reset_reg_write", 32'(reg_write), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // ADD then SRAI back-to-back
        $display("[TB] back-to-back ADD / SRAI");
        applyStimulus(1'b1, enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd3), 32'h100,
                      32'h11111111, 32'h22222222, 1'b1, 1'b0);
        tick();
        checkOutput("add_valid", 32'(out_valid), 32'd1);
        checkOutput("add_select", 32'(alu_select), 32'h00);
        checkOutput("add_data1", alu_data1, 32'h11111111);
        checkOutput("add_data2", alu_data2, 32'h22222222);
        checkOutput("add_rd", 32'(rd), 32'd3);
        checkOutput("add_reg_write", 32'(reg_write), 32'd1);
        checkOutput("add_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, enc_i(12'h403, 5'd4, 3'b101, 5'd5, 7'b0010011), 32'h104,
                      32'h80000000, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("srai_valid", 32'(out_valid), 32'd1);
        checkOutput("srai_select", 32'(alu_select), 32'h15);
        checkOutput("srai_data1", alu_data1, 32'h80000000);
        checkOutput("srai_data2", alu_data2, 32'd3);
        checkOutput("srai_rd", 32'(rd), 32'd5);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("drain_empty", 32'(out_valid), 32'd0);

        // MULHU x6,x1,x2
        $display("[TB] MULHU");
        applyStimulus(1'b1, enc_r(7'b0000001, 5'd2, 5'd1, 3'b011, 5'd6), 32'h108,
                      32'd5, 32'd7, 1'b1, 1'b0);
        tick();
`ifdef RV32M_EN
        checkOutput("mulhu_hold1_valid", 32'(out_valid), 32'd0);
        checkOutput("mulhu_hold1_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("mulhu_hold2_valid", 32'(out_valid), 32'd0);
        checkOutput("mulhu_hold2_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("mulhu_valid", 32'(out_valid), 32'd1);
        checkOutput("mulhu_select", 32'(alu_select), 32'h0B);
        checkOutput("mulhu_data1", alu_data1, 32'd5);
        checkOutput("mulhu_data2", alu_data2, 32'd7);
        checkOutput("mulhu_rd", 32'(rd), 32'd6);
        checkOutput("mulhu_reg_write", 32'(reg_write), 32'd1);
`else
        checkOutput("mulhu_valid", 32'(out_valid), 32'd1);
        checkOutput("mulhu_illegal", 32'(illegal), 32'd1);
        checkOutput("mulhu_select", 32'(alu_select), 32'h00);
        checkOutput("mulhu_data1", alu_data1, 32'd0);
        checkOutput("mulhu_reg_write", 32'(reg_write), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
`endif
        tick();
        checkOutput("mulhu_drained", 32'(out_valid), 32'd0);

        // Downstream stall for 5 cycles
        $display("[TB] stall");
        applyStimulus(1'b1, enc_r(7'b0, 5'd2, 5'd1, 3'b100, 5'd8), 32'h10C,
                      32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b0);
        tick();
        checkOutput("xor_valid", 32'(out_valid), 32'd1);
        checkOutput("xor_select", 32'(alu_select), 32'h04);
        applyStimulus(1'b1, enc_r(7'b0, 5'd2, 5'd1, 3'b110, 5'd9), 32'h110,
                      32'h12340000, 32'h00005678, 1'b0, 1'b0);
        #1;
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("stall%0d_select", k), 32'(alu_select), 32'h04);
            checkOutput($sformatf("stall%0d_data1", k), alu_data1, 32'hF0F0F0F0);
            checkOutput($sformatf("stall%0d_data2", k), alu_data2, 32'h0FF00FF0);
            checkOutput($sformatf("stall%0d_rd", k), 32'(rd), 32'd8);
        end
        applyStimulus(1'b1, enc_r(7'b0, 5'd2, 5'd1, 3'b110, 5'd9), 32'h110,
                      32'h12340000, 32'h00005678, 1'b1, 1'b0);
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("or_valid", 32'(out_valid), 32'd1);
        checkOutput("or_select", 32'(alu_select), 32'h06);
        checkOutput("or_data1", alu_data1, 32'h12340000);
        checkOutput("or_data2", alu_data2, 32'h00005678);
        checkOutput("or_rd", 32'(rd), 32'd9);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("or_drained", 32'(out_valid), 32'd0);

        // Back-to-back decode vectors
        $display("[TB] decode vectors");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("vec%0d_select", i), 32'(alu_select), vecs[i].sel);
            checkOutput($sformatf("vec%0d_data1", i), alu_data1, vecs[i].d1);
            checkOutput($sformatf("vec%0d_data2", i), alu_data2, vecs[i].d2);
            checkOutput($sformatf("vec%0d_rd", i), 32'(rd), vecs[i].rdn);
            checkOutput($sformatf("vec%0d_reg_write", i), 32'(reg_write), vecs[i].wr);
            checkOutput($sformatf("vec%0d_illegal", i), 32'(illegal), vecs[i].ill);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("vec_drained", 32'(out_valid), 32'd0);

        // Flush
        $display("[TB] flush");
`ifdef RV32M_EN
        applyStimulus(1'b1, enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd15), 32'h500,
                      32'd3, 32'd4, 1'b1, 1'b0);
        tick();
        checkOutput("mul_in_hold", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        checkOutput("flush_hold_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_hold_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("flushed_mul%0d_valid", k), 32'(out_valid), 32'd0);
        end
`endif
        applyStimulus(1'b1, vecs[8].instr, vecs[8].pc, 32'd50, 32'd8, 1'b0, 1'b0);
        tick();
        checkOutput("pre_flush_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b1, enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd3), 32'h504,
                      32'd1, 32'd2, 1'b1, 1'b1);
        tick();
        checkOutput("flush_full_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_full_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("flush_dropped_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset while FULL
        $display("[TB] async reset");
        applyStimulus(1'b1, vecs[8].instr, vecs[8].pc, 32'd9, 32'd4, 1'b0, 1'b0);
        tick();
        checkOutput("prereset_select", 32'(alu_select), 32'h10);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("areset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("areset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("areset_select", 32'(alu_select), 32'd0);
        checkOutput("areset_data1", alu_data1, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Decode/issue pipeline stage for the RV32IM core.
- Takes a fetched instruction plus its register-file operands, and produces the 6-bit ALU SELECT code and the two 32-bit ALU operands in a registered output slot.
- Uses valid/ready handshakes on both sides.
- Holds M-extension ops for extra cycles so the slow multiply/divide paths settle before downstream capture.

Parameters:
- M_HOLD_CYCLES, 2, extra cycles an M-extension op stays in HOLD before OUT_VALID rises (0 = no hold).

Ports:
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- FLUSH  in  1  synchronous pipeline kill, highest priority
- IN_VALID  in  1  upstream instruction valid
- IN_READY  out  1  stage can accept this cycle
- INSTR  in  32  instruction word
- PC  in  32  instruction address
- RS1_DATA  in  32  rs1 register value
- RS2_DATA  in  32  rs2 register value
- OUT_VALID  out  1  issue slot holds a ready op
- OUT_READY  in  1  downstream accepts
- ALU_SELECT  out  6  ALU operation code
- ALU_DATA1  out  32  ALU operand 1
- ALU_DATA2  out  32  ALU operand 2
- RD  out  5  destination register
- REG_WRITE  out  1  writeback enable
- ILLEGAL  out  1  unsupported or undefined encoding

Behaviour:
- Reset (RESET_N low, asynchronous): state EMPTY; hold counter 0. All outputs 0 except IN_READY=1.
- States and transitions:
  - EMPTY: IN_READY=1, OUT_VALID=0. On IN_VALID, capture the decode. Go to HOLD if it is an M op and M_HOLD_CYCLES>0 (counter=M_HOLD_CYCLES-1); otherwise go to FULL.
  - HOLD: IN_READY=0, OUT_VALID=0. Counter decrements each cycle; at 0 go to FULL.
  - FULL: OUT_VALID=1, IN_READY=OUT_READY.
    - OUT_READY & IN_VALID: capture the new op (to FULL or HOLD). Back-to-back, zero bubble.
    - OUT_READY only: go to EMPTY.
    - !OUT_READY: all outputs frozen bit-exact.
- FLUSH: next state EMPTY, OUT_VALID=0. Any input offered that cycle is dropped. Overrides every other transition, including HOLD mid-count.
- Latency: 1 cycle for non-M ops; 1+M_HOLD_CYCLES for M ops.
- SELECT encoding, where f3=funct3 and f7=funct7:
  - OP, f7=0000000: {000,f3}.
  - OP, f7=0100000: f3=000 gives 010000; f3=101 gives 010101; any other f3 is ILLEGAL.
  - OP, f7=0000001 (M op): f3 000-011 gives {001,f3}; 100 gives 001100; 110 gives 001101; 111 gives 001111. f3=101 (DIVU) is ILLEGAL.
  - OP operands: DATA1=RS1, DATA2=RS2.
  - OP-IMM: {000,f3}; f3=101 with INSTR[30]=1 gives 010101. Immediate is sign-extended; shifts use zero-extended shamt INSTR[24:20].
  - LOAD/STORE: 000000; DATA1=RS1, DATA2=sext I-imm or S-imm.
  - BRANCH: BEQ/BNE give 010000; BLT/BGE give 000010; BLTU/BGEU give 000011. Operands RS1/RS2; REG_WRITE=0.
  - LUI: 011000 (forward); DATA1=0, DATA2=U-imm.
  - AUIPC: 000000; DATA1=PC, DATA2=U-imm.
  - JAL/JALR: 000000; DATA1=PC, DATA2=32'd4.
- REG_WRITE=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR. Forced to 0 when RD=0 or ILLEGAL.
- Illegal ops: any undefined opcode gives ILLEGAL=1, SELECT=000000, both operands 0. The op still flows through the handshake as an ordinary non-M op.

Optional Feature:
- Macro: RV32M_EN.
- Defined: M ops decode as above and use the HOLD state.
- Undefined: every f7=0000001 OP encoding is ILLEGAL. HOLD is unreachable; the counter logic is compiled out.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_SELECT localparams (ALU_ADD=6'b000000 … ALU_FWD=6'b011000);
  - RV32 opcode constants;
  - the state enum.
- Sub-module alu_op_decode: purely combinational INSTR/PC/RS to SELECT/operands/RD/REG_WRITE/ILLEGAL.
- alu_op_issue owns the FSM, the hold counter and the output registers.

Test Plan:
- Reset: RESET_N low mid-FULL → OUT_VALID=0, IN_READY=1 immediately (asynchronous), ALU_SELECT=0.
- ADD x3,x1,x2 then SRAI x5,x4,3 (RS1=0x80000000), back-to-back with OUT_READY=1:
  - ADD: SELECT=000000, DATA1/DATA2=RS1/RS2, RD=3, REG_WRITE=1.
  - SRAI: SELECT=010101, DATA2=3.
  - OUT_VALID high on consecutive cycles.
- MULHU x6,x1,x2 with M_HOLD_CYCLES=2 → OUT_VALID rises 3 cycles after acceptance, SELECT=001011, IN_READY=0 during HOLD.
- FULL with OUT_READY=0 for 5 cycles → outputs stable; IN_VALID ignored; released op appears next.
- LUI x7,0x12345 → SELECT=011000, DATA2=0x12345000. DIVU → ILLEGAL=1, REG_WRITE=0. ADDI x0,x0,1 → REG_WRITE=0.
- FLUSH during HOLD → EMPTY next cycle, OUT_VALID never asserts for the flushed op.
